axi_bridge_mo: RTL and testbench



---
 rtl/axi_bridge_mo.sv | 196 +++++++++++++++++++
 tb/tb_axi_bridge_mo.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bridge_mo.sv
// SRAM-like inst/data ports to a single AXI3 master with up to MAX_OUT outstanding
// transactions per stream (inst read, data read, data write) and in-order data_ok.
module axi_bridge_mo #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic                aclk,
  input  logic                aresetn,
  output logic [3:0]          arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [3:0]          rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [3:0]          awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awvalid,
  input  logic                awready,
  output logic [3:0]          wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [3:0]          bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  input  logic                inst_sram_req,
  input  logic                inst_sram_wr,
  input  logic [DATA_W/8-1:0] inst_sram_wstrb,
  input  logic [1:0]          inst_sram_size,
  input  logic [ADDR_W-1:0]   inst_sram_addr,
  input  logic [DATA_W-1:0]   inst_sram_wdata,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [DATA_W-1:0]   inst_sram_rdata,
  input  logic                data_sram_req,
  input  logic                data_sram_wr,
  input  logic [DATA_W/8-1:0] data_sram_wstrb,
  input  logic [1:0]          data_sram_size,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic                data_sram_addr_ok,
  output logic                data_sram_data_ok,
  output logic [DATA_W-1:0]   data_sram_rdata
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  logic             live;
  logic [CNT_W-1:0] ird_cnt, drd_cnt, wr_cnt;
  logic             ar_free, aw_free, w_free;
  logic             drd_acc, ird_acc, wr_acc;
  logic             r_hs, ird_done, drd_done, wr_done;
  logic             unused_inputs;

  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = 4'd1;
  assign awlen   = 8'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;
  assign rready  = live;
  assign bready  = live;

  assign unused_inputs = ^{rresp, rlast, bresp, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata};

  // Handshake: a transfer happens on a rising aclk where valid & ready are both 1; a
  // stage holds payload stable while valid & ~ready and is reusable in its handshake cycle.
  assign ar_free = ~arvalid | arready;
  assign aw_free = ~awvalid | awready;
  assign w_free  = ~wvalid | wready;

  // Reads and writes on the data port never overlap, so data_ok order is request order.
  assign drd_acc = live & data_sram_req & ~data_sram_wr & ar_free & (drd_cnt < MAX_CNT)
                 & (wr_cnt == '0) & aw_free & w_free;
  assign ird_acc = live & inst_sram_req & ar_free & (ird_cnt < MAX_CNT) & ~drd_acc;
  assign wr_acc  = live & data_sram_req & data_sram_wr & aw_free & w_free
                 & (wr_cnt < MAX_CNT) & (drd_cnt == '0);

  assign inst_sram_addr_ok = ird_acc;
  assign data_sram_addr_ok = drd_acc | wr_acc;

  assign r_hs     = rvalid & rready;
  assign ird_done = r_hs & (rid == 4'd0);
  assign drd_done = r_hs & (rid == 4'd1);
  assign wr_done  = bvalid & bready & (bid == 4'd1);

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    return c + CNT_W'(inc) - CNT_W'(dec);
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live    <= 1'b0;
      ird_cnt <= '0;
      drd_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      live    <= 1'b1;
      ird_cnt <= next_cnt(ird_cnt, ird_acc, ird_done);
      drd_cnt <= next_cnt(drd_cnt, drd_acc, drd_done);
      wr_cnt  <= next_cnt(wr_cnt, wr_acc, wr_done);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid <= 1'b0;
      arid    <= 4'd0;
      araddr  <= '0;
      arsize  <= 3'd0;
    end else if (ar_free) begin
      arvalid <= drd_acc | ird_acc;
      if (drd_acc) begin
        arid   <= 4'd1;
        araddr <= data_sram_addr;
        arsize <= {1'b0, data_sram_size};
      end else if (ird_acc) begin
        arid   <= 4'd0;
        araddr <= inst_sram_addr;
        arsize <= {1'b0, inst_sram_size};
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awvalid <= 1'b0;
      awaddr  <= '0;
      awsize  <= 3'd0;
    end else if (wr_acc) begin
      awvalid <= 1'b1;
      awaddr  <= data_sram_addr;
      awsize  <= {1'b0, data_sram_size};
    end else if (awready) begin
      awvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wvalid <= 1'b0;
      wdata  <= '0;
      wstrb  <= '0;
    end else if (wr_acc) begin
      wvalid <= 1'b1;
      wdata  <= data_sram_wdata;
      wstrb  <= data_sram_wstrb;
    end else if (wready) begin
      wvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inst_sram_data_ok <= 1'b0;
      data_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= '0;
      data_sram_rdata   <= '0;
    end else begin
      inst_sram_data_ok <= ird_done;
      data_sram_data_ok <= drd_done | wr_done;
      if (ird_done) inst_sram_rdata <= rdata;
      if (drd_done) data_sram_rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_axi_bridge_mo.sv
// Bench for axi_bridge_mo: directed scenarios with literal expectations, then random
// traffic against a queue/counter model of the bridge and a responding AXI slave.
module tb_axi_bridge_mo;
  localparam int ADDR_W = 32, DATA_W = 32, MAX_OUT = 4, CNT_W = 3;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [3:0] arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0] arcache, awcache, wstrb;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;
  logic inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [3:0] inst_sram_wstrb, data_sram_wstrb;
  logic [1:0] inst_sram_size, data_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

  axi_bridge_mo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata)
  );

  // ---------------- model state ----------------
  int checks = 0, failures = 0;
  bit live;
  int m_ird, m_drd, m_wr;
  bit ar_pend, aw_pend, w_pend;
  logic [3:0] e_arid;
  logic [31:0] e_araddr, e_awaddr, e_wdata;
  logic [2:0] e_arsize, e_awsize;
  logic [3:0] e_wstrb;
  bit m_iok, m_dok, m_dok_rd;
  logic [31:0] m_irdata, m_drdata;
  logic a_ird, a_drd, a_wr;
  logic [31:0] sl_iq[$], sl_dq[$];
  int aw_done, w_done, b_sent;
  logic [DATA_W-1:0] exp_q[$];

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    live = 0; m_ird = 0; m_drd = 0; m_wr = 0;
    ar_pend = 0; aw_pend = 0; w_pend = 0;
    m_iok = 0; m_dok = 0; m_dok_rd = 0; m_irdata = '0; m_drdata = '0;
    sl_iq.delete(); sl_dq.delete(); exp_q.delete();
    aw_done = 0; w_done = 0; b_sent = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_core();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_wstrb = '0; inst_sram_size = 2'd0;
    inst_sram_addr = '0; inst_sram_wdata = '0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_wstrb = '0; data_sram_size = 2'd0;
    data_sram_addr = '0; data_sram_wdata = '0;
  endtask

  task automatic idle_slave();
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1;
    bvalid = 0; bid = '0; bresp = '0;
  endtask

  task automatic core_drive();
    inst_sram_req   = 1'($urandom_range(0, 1));
    inst_sram_wr    = 1'($urandom_range(0, 1));
    inst_sram_wstrb = 4'($urandom);
    inst_sram_wdata = $urandom;
    inst_sram_size  = 2'($urandom_range(0, 2));
    inst_sram_addr  = $urandom & 32'hFFFF_FFFC;
    data_sram_req   = 1'($urandom_range(0, 1));
    data_sram_wr    = 1'($urandom_range(0, 1));
    data_sram_wstrb = 4'($urandom_range(1, 15));
    data_sram_wdata = $urandom;
    data_sram_size  = 2'($urandom_range(0, 2));
    data_sram_addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
    arready = ($urandom_range(0, 3) != 0);
    awready = 1'($urandom_range(0, 1));
    wready  = 1'($urandom_range(0, 1));
  endtask

  // AXI slave: answers outstanding reads/writes, sometimes with ids the bridge must ignore.
  task automatic slave_drive();
    rvalid = 0; rid = '0; rdata = '0; bvalid = 0; bid = '0;
    if (!live) return;
    if ($urandom_range(0, 2) != 0) begin
      if (sl_iq.size() > 0 && (sl_dq.size() == 0 || $urandom_range(0, 1) == 1)) begin
        rvalid = 1; rid = 4'd0; rdata = $urandom;
      end else if (sl_dq.size() > 0) begin
        rvalid = 1; rid = 4'd1; rdata = fdat(sl_dq[0]);
      end else if ($urandom_range(0, 7) == 0) begin
        rvalid = 1; rid = 4'($urandom_range(2, 15)); rdata = $urandom;
      end
    end
    if (aw_done > b_sent && w_done > b_sent && $urandom_range(0, 1) == 1) begin
      bvalid = 1; bid = 4'd1;
    end else if ($urandom_range(0, 15) == 0) begin
      bvalid = 1; bid = 4'($urandom_range(2, 15));
    end
  endtask

  // ---------------- compare + model update ----------------
  task automatic compare();
    logic ar_free, waw_free;
    ar_free  = !ar_pend || arready;
    waw_free = (!aw_pend || awready) && (!w_pend || wready);
    a_drd = live && data_sram_req && !data_sram_wr && ar_free && m_drd < MAX_OUT
            && m_wr == 0 && waw_free;
    a_ird = live && inst_sram_req && ar_free && m_ird < MAX_OUT && !a_drd;
    a_wr  = live && data_sram_req && data_sram_wr && waw_free && m_wr < MAX_OUT && m_drd == 0;
    chk("addr_ok", {inst_sram_addr_ok, data_sram_addr_ok}, {a_ird, a_drd | a_wr});
    chk("ready", {rready, bready}, {live, live});
    chk("valids", {arvalid, awvalid, wvalid}, {ar_pend, aw_pend, w_pend});
    if (ar_pend) chk("ar_payload", {arid, araddr, arsize}, {e_arid, e_araddr, e_arsize});
    if (aw_pend) chk("aw_payload", {awaddr, awsize}, {e_awaddr, e_awsize});
    if (w_pend) chk("w_payload", {wdata, wstrb}, {e_wdata, e_wstrb});
    chk("data_ok", {inst_sram_data_ok, data_sram_data_ok}, {m_iok, m_dok});
    chk("inst_rdata", inst_sram_rdata, m_irdata);
    chk("data_rdata", data_sram_rdata, m_drdata);
    if (m_dok && m_dok_rd && exp_q.size() > 0)
      chk("data_rd_order", data_sram_rdata, exp_q.pop_front());
  endtask

  task automatic commit();
    bit n_iok, n_dok, n_dok_rd;
    if (!aresetn) begin model_reset(); return; end
    n_iok = 0; n_dok = 0; n_dok_rd = 0;
    if (live && rvalid) begin
      if (rid == 4'd0 && sl_iq.size() > 0) begin
        m_ird--; n_iok = 1; m_irdata = rdata; void'(sl_iq.pop_front());
      end else if (rid == 4'd1 && sl_dq.size() > 0) begin
        m_drd--; n_dok = 1; n_dok_rd = 1; m_drdata = rdata; void'(sl_dq.pop_front());
      end
    end
    if (live && bvalid && bid == 4'd1) begin m_wr--; n_dok = 1; n_dok_rd = 0; b_sent++; end
    if (ar_pend && arready) begin
      if (e_arid == 4'd0) sl_iq.push_back(e_araddr); else sl_dq.push_back(e_araddr);
      ar_pend = 0;
    end
    if (a_drd) begin
      ar_pend = 1; e_arid = 4'd1; e_araddr = data_sram_addr; e_arsize = {1'b0, data_sram_size};
      m_drd++; exp_q.push_back(fdat(data_sram_addr));
    end else if (a_ird) begin
      ar_pend = 1; e_arid = 4'd0; e_araddr = inst_sram_addr; e_arsize = {1'b0, inst_sram_size};
      m_ird++;
    end
    if (aw_pend && awready) begin aw_pend = 0; aw_done++; end
    if (w_pend && wready) begin w_pend = 0; w_done++; end
    if (a_wr) begin
      aw_pend = 1; w_pend = 1; m_wr++;
      e_awaddr = data_sram_addr; e_awsize = {1'b0, data_sram_size};
      e_wdata = data_sram_wdata; e_wstrb = data_sram_wstrb;
    end
    m_iok = n_iok; m_dok = n_dok; m_dok_rd = n_dok_rd;
    live = 1;
  endtask

  // Called at a negedge after inputs are set; returns at the next negedge.
  task automatic cyc();
    #1;
    compare();
    commit();
    @(negedge aclk);
  endtask

  task automatic drain(input string tag);
    int budget = 300;
    idle_core(); arready = 1; awready = 1; wready = 1;
    while ((m_ird != 0 || m_drd != 0 || m_wr != 0 || ar_pend || aw_pend || w_pend || m_iok || m_dok)
           && budget > 0) begin
      slave_drive();
      cyc();
      budget--;
    end
    rvalid = 0; bvalid = 0;
    if (budget == 0) begin
      checks++; failures++;
      $display("FAIL drain_%s outstanding ird=%0d drd=%0d wr=%0d required=0", tag, m_ird, m_drd, m_wr);
    end
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_ok;
    idle_core(); idle_slave(); model_reset();
    repeat (2) @(negedge aclk);
    chk("rst_outs", {arvalid, awvalid, wvalid, rready, bready, inst_sram_addr_ok,
                     data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}, 64'd0);
    chk("rst_rdata", {inst_sram_rdata, data_sram_rdata}, 64'd0);
    chk("ar_ties", {arlen, arburst, arlock, arcache, arprot}, {8'd0, 2'd1, 2'd0, 4'd0, 3'd0});
    chk("aw_ties", {awid, awlen, awburst, awlock, awcache, awprot, wid, wlast},
        {4'd1, 8'd0, 2'd1, 2'd0, 4'd0, 3'd0, 4'd1, 1'b1});
    aresetn = 1;
    cyc();

    // inst read
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2; arready = 1;
    #1 chk("t1_addr_ok", inst_sram_addr_ok, 1'b1);
    cyc();
    inst_sram_req = 0;
    chk("t1_ar", {arvalid, arid, araddr, arsize}, {1'b1, 4'd0, 32'h1C00_0000, 3'd2});
    cyc();
    rvalid = 1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
    cyc();
    rvalid = 0;
    chk("t1_data_ok", {inst_sram_data_ok, inst_sram_rdata}, {1'b1, 32'hDEAD_BEEF});
    cyc();

    // data read wins over inst read
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0040;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_2000; data_sram_size = 2'd2;
    #1 chk("t2_first", {data_sram_addr_ok, inst_sram_addr_ok}, 2'b10);
    cyc();
    data_sram_req = 0;
    chk("t2_ar_data", {arvalid, arid, araddr}, {1'b1, 4'd1, 32'h0000_2000});
    #1 chk("t2_second", inst_sram_addr_ok, 1'b1);
    cyc();
    inst_sram_req = 0;
    chk("t2_ar_inst", {arid, araddr}, {4'd0, 32'h1C00_0040});
    drain("t2");

    // write then read of the same address
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_1000;
    data_sram_wdata = 32'h1234_5678; data_sram_wstrb = 4'hF; data_sram_size = 2'd2;
    awready = 1; wready = 1;
    #1 chk("t3_wr_ok", data_sram_addr_ok, 1'b1);
    cyc();
    data_sram_wr = 0;
    chk("t3_aw_w", {awvalid, wvalid, awaddr, wdata}, {2'b11, 32'h0000_1000, 32'h1234_5678});
    #1 chk("t3_rd_blocked_a", data_sram_addr_ok, 1'b0);
    cyc();
    #1 chk("t3_rd_blocked_b", data_sram_addr_ok, 1'b0);
    cyc();
    bvalid = 1; bid = 4'd1;
    #1 chk("t3_rd_blocked_c", data_sram_addr_ok, 1'b0);
    cyc();
    bvalid = 0;
    chk("t3_wr_data_ok", data_sram_data_ok, 1'b1);
    #1 chk("t3_rd_ok", data_sram_addr_ok, 1'b1);
    cyc();
    data_sram_req = 0;
    drain("t3");

    // AW stalled, W accepted at once
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_3000;
    data_sram_wdata = 32'hCAFE_F00D; data_sram_wstrb = 4'h3; data_sram_size = 2'd1;
    awready = 0; wready = 1;
    #1 chk("t4_wr_ok", data_sram_addr_ok, 1'b1);
    cyc();
    data_sram_addr = 32'h0000_3004;
    for (int j = 0; j < 3; j++) begin
      chk("t4_stall", {awvalid, wvalid, awaddr}, {1'b1, 1'(j == 0), 32'h0000_3000});
      #1 chk("t4_no_second", data_sram_addr_ok, 1'b0);
      cyc();
    end
    awready = 1;
    chk("t4_aw_4th", {awvalid, awaddr}, {1'b1, 32'h0000_3000});
    #1 chk("t4_second_ok", data_sram_addr_ok, 1'b1);
    cyc();
    drain("t4");

    // asynchronous reset with AR and AW/W in flight
    inst_sram_req = 1; inst_sram_addr = 32'h0000_0500;
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_0600;
    arready = 1; awready = 0; wready = 0;
    cyc();
    arready = 0;
    chk("t5_inflight", {arvalid, awvalid, wvalid}, 3'b111);
    #2 aresetn = 0;
    #1 chk("t5_async_clear", {arvalid, awvalid, wvalid, rready, bready, inst_sram_addr_ok,
                              data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok}, 64'd0);
    chk("t5_rdata_clear", {inst_sram_rdata, data_sram_rdata}, 64'd0);
    model_reset();
    idle_core(); idle_slave();
    @(negedge aclk);
    aresetn = 1;
    cyc();

    // outstanding limit on the inst stream (also shows counters restarted at 0)
    n_ok = 0;
    arready = 1; inst_sram_req = 1; inst_sram_size = 2'd2;
    for (int k = 0; k < 6; k++) begin
      inst_sram_addr = 32'h0000_0100 + 32'(k * 4);
      #1 n_ok += int'(inst_sram_addr_ok);
      cyc();
    end
    chk("t6_accepts", n_ok, 4);
    rvalid = 1; rid = 4'd0; rdata = 32'h5555_AAAA;
    #1 chk("t6_full", inst_sram_addr_ok, 1'b0);
    cyc();
    rvalid = 0;
    #1 chk("t6_fifth_ok", inst_sram_addr_ok, 1'b1);
    cyc();
    drain("t6");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      core_drive();
      slave_drive();
      cyc();
    end
    drain("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
